nmi_demux: RTL and testbench



---
 rtl/nmi_demux_if.sv | 31 +++
 rtl/nmi_demux.sv | 226 ++++++++++++++++++++++
 tb/tb_nmi_demux.sv | 282 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/nmi_demux_if.sv
// ---------------------------------------------------------------------------
// nmi_demux_if
// Master-side NMI request/response bus between the core and nmi_demux.
//   m_valid  : request, held by the master until m_ready
//   m_addr   : 32-bit address, [31:24] selects the slave
//   m_wdata  : 32-bit write data
//   m_wstrb  : byte strobes, 4'b0000 means read
//   m_ready  : one-cycle completion pulse
//   m_rdata  : read data, valid with m_ready
//   m_err    : error flag, valid with m_ready
// Modports: master (the core) and slave (the demux).
// ---------------------------------------------------------------------------
interface nmi_demux_if;
    logic        m_valid;
    logic [31:0] m_addr;
    logic [31:0] m_wdata;
    logic [3:0]  m_wstrb;
    logic        m_ready;
    logic [31:0] m_rdata;
    logic        m_err;

    modport master (
        output m_valid, m_addr, m_wdata, m_wstrb,
        input  m_ready, m_rdata, m_err
    );

    modport slave (
        input  m_valid, m_addr, m_wdata, m_wstrb,
        output m_ready, m_rdata, m_err
    );
endinterface

// File: rtl/nmi_demux.sv
// ---------------------------------------------------------------------------
// nmi_demux
// Registered NMI request demultiplexer: one master fans out to NUM_SLV slave
// ports selected by addr[31:24]. Lowest matching slave index wins; a miss
// returns an error response without touching any slave. Slaves flagged in
// FIXLAT_MASK have a fixed one-cycle latency and no ready.
//
// Optional feature macro: NMI_DEMUX_TIMEOUT_EN enables a per-access timeout
// that ends a handshake access with err=1 after TMO_CYC cycles without ready.
//
// Ports:
//   clk_i, rst_i : clock, synchronous active-high reset
//   m            : master bus (nmi_demux_if.slave)
//   s_valid_o    : one-hot slave request
//   s_addr_o     : registered broadcast address
//   s_wdata_o    : registered broadcast write data
//   s_wstrb_o    : registered strobes, zero whenever no slave is requested
//   s_rdata_i    : slave read data, 32-bit slice i for slave i
//   s_ready_i    : slave completion, ignored for fixed-latency slaves
// ---------------------------------------------------------------------------
module nmi_demux #(
    parameter int                      NUM_SLV     = 6,
    parameter logic [NUM_SLV*8-1:0]    SLV_BASE    = '0,
    parameter logic [NUM_SLV-1:0]      FIXLAT_MASK = '0,
    parameter int                      TMO_CYC     = 255
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    nmi_demux_if.slave             m,
    output logic [NUM_SLV-1:0]     s_valid_o,
    output logic [31:0]            s_addr_o,
    output logic [31:0]            s_wdata_o,
    output logic [3:0]             s_wstrb_o,
    input  logic [NUM_SLV*32-1:0]  s_rdata_i,
    input  logic [NUM_SLV-1:0]     s_ready_i
);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ACCESS  = 3'd1,
        ST_FIXWAIT = 3'd2,
        ST_DECERR  = 3'd3,
        ST_RESP    = 3'd4
    } state_e;

    state_e               state_q,   state_d;
    logic [NUM_SLV-1:0]   sel_q,     sel_d;
    logic [NUM_SLV-1:0]   s_valid_q, s_valid_d;
    logic [31:0]          s_addr_q,  s_addr_d;
    logic [31:0]          s_wdata_q, s_wdata_d;
    logic [3:0]           s_wstrb_q, s_wstrb_d;
    logic                 m_ready_q, m_ready_d;
    logic [31:0]          m_rdata_q, m_rdata_d;
    logic                 m_err_q,   m_err_d;

    logic                 hit_s;
    logic [NUM_SLV-1:0]   dec_sel_s;
    logic                 sel_ready_s;
    logic                 sel_fix_s;
    logic [31:0]          sel_rdata_s;

`ifdef NMI_DEMUX_TIMEOUT_EN
    localparam int TMO_W = (TMO_CYC > 0) ? $clog2(TMO_CYC + 1) : 1;
    logic [TMO_W-1:0]     tmo_cnt_q, tmo_cnt_d;
`else
    // Timeout limit has no function in this build.
    logic                 unused_tmo_s;
    assign unused_tmo_s = TMO_CYC[0];
`endif

    // Address decode: scan high to low so the lowest matching index is kept.
    always_comb begin
        hit_s     = 1'b0;
        dec_sel_s = '0;
        for (int i = NUM_SLV - 1; i >= 0; i--) begin
            if (SLV_BASE[i*8 +: 8] == m.m_addr[31:24]) begin
                hit_s        = 1'b1;
                dec_sel_s    = '0;
                dec_sel_s[i] = 1'b1;
            end else begin
                hit_s     = hit_s;
                dec_sel_s = dec_sel_s;
            end
        end
    end

    // Per-slave view of the latched select: its ready, its latency type, its data.
    always_comb begin
        sel_ready_s = |(s_ready_i & sel_q);
        sel_fix_s   = |(FIXLAT_MASK & sel_q);
        sel_rdata_s = 32'h0000_0000;
        for (int i = 0; i < NUM_SLV; i++) begin
            sel_rdata_s = sel_rdata_s | ({32{sel_q[i]}} & s_rdata_i[i*32 +: 32]);
        end
    end

    // Next-state and next-output logic; outputs are computed for the state
    // being entered so every output comes straight from a flop.
    always_comb begin
        state_d   = state_q;
        sel_d     = sel_q;
        s_valid_d = s_valid_q;
        s_addr_d  = s_addr_q;
        s_wdata_d = s_wdata_q;
        s_wstrb_d = s_wstrb_q;
        m_ready_d = 1'b0;
        m_rdata_d = 32'h0000_0000;
        m_err_d   = 1'b0;
`ifdef NMI_DEMUX_TIMEOUT_EN
        tmo_cnt_d = tmo_cnt_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (m.m_valid) begin
                    if (hit_s) begin
                        state_d   = ST_ACCESS;
                        sel_d     = dec_sel_s;
                        s_valid_d = dec_sel_s;
                        s_addr_d  = m.m_addr;
                        s_wdata_d = m.m_wdata;
                        s_wstrb_d = m.m_wstrb;
`ifdef NMI_DEMUX_TIMEOUT_EN
                        tmo_cnt_d = '0;
`endif
                    end else begin
                        state_d = ST_DECERR;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ACCESS: begin
                // Fixed-latency slaves get exactly one request cycle; their ready is ignored.
                if (sel_fix_s) begin
                    state_d   = ST_FIXWAIT;
                    s_valid_d = '0;
                    s_wstrb_d = 4'b0000;
                end else if (sel_ready_s) begin
                    // A ready in the same cycle the counter expires still wins.
                    state_d   = ST_RESP;
                    s_valid_d = '0;
                    s_wstrb_d = 4'b0000;
                    m_ready_d = 1'b1;
                    m_rdata_d = sel_rdata_s;
                    m_err_d   = 1'b0;
`ifdef NMI_DEMUX_TIMEOUT_EN
                end else if (tmo_cnt_q == TMO_W'(TMO_CYC)) begin
                    state_d   = ST_RESP;
                    s_valid_d = '0;
                    s_wstrb_d = 4'b0000;
                    m_ready_d = 1'b1;
                    m_rdata_d = 32'h0000_0000;
                    m_err_d   = 1'b1;
                end else begin
                    tmo_cnt_d = tmo_cnt_q + TMO_W'(1);
                end
`else
                end else begin
                    state_d = ST_ACCESS;
                end
`endif
            end
            ST_FIXWAIT: begin
                // Fixed-latency data is valid the cycle after the request.
                state_d   = ST_RESP;
                m_ready_d = 1'b1;
                m_rdata_d = sel_rdata_s;
                m_err_d   = 1'b0;
            end
            ST_DECERR: begin
                state_d   = ST_RESP;
                m_ready_d = 1'b1;
                m_rdata_d = 32'h0000_0000;
                m_err_d   = 1'b1;
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d   = ST_IDLE;
                s_valid_d = '0;
                s_wstrb_d = 4'b0000;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= ST_IDLE;
            sel_q     <= '0;
            s_valid_q <= '0;
            s_addr_q  <= 32'h0000_0000;
            s_wdata_q <= 32'h0000_0000;
            s_wstrb_q <= 4'b0000;
            m_ready_q <= 1'b0;
            m_rdata_q <= 32'h0000_0000;
            m_err_q   <= 1'b0;
`ifdef NMI_DEMUX_TIMEOUT_EN
            tmo_cnt_q <= '0;
`endif
        end else begin
            state_q   <= state_d;
            sel_q     <= sel_d;
            s_valid_q <= s_valid_d;
            s_addr_q  <= s_addr_d;
            s_wdata_q <= s_wdata_d;
            s_wstrb_q <= s_wstrb_d;
            m_ready_q <= m_ready_d;
            m_rdata_q <= m_rdata_d;
            m_err_q   <= m_err_d;
`ifdef NMI_DEMUX_TIMEOUT_EN
            tmo_cnt_q <= tmo_cnt_d;
`endif
        end
    end

    assign s_valid_o = s_valid_q;
    assign s_addr_o  = s_addr_q;
    assign s_wdata_o = s_wdata_q;
    assign s_wstrb_o = s_wstrb_q;
    assign m.m_ready = m_ready_q;
    assign m.m_rdata = m_rdata_q;
    assign m.m_err   = m_err_q;

endmodule

// File: tb/tb_nmi_demux.sv
// ---------------------------------------------------------------------------
// tb_nmi_demux
// Self-checking bench for nmi_demux. The reference model derives each
// transaction's cycle-by-cycle expectation (which slave, how long s_valid is
// high, when m_ready pulses and with which data/err) from the decode table
// and latency rules alone.
// Map: slave0=01 slave1=02(fixlat) slave2=03 slave3=04(fixlat)
//      slave4=20 slave5=20 (shadowed by slave4). TMO_CYC=4.
// ---------------------------------------------------------------------------
module tb_nmi_demux;
    localparam int NS    = 6;
    localparam int TMO   = 4;
    localparam int NEVER = 100000;
    localparam logic [NS*8-1:0] BASES = {8'h20, 8'h20, 8'h04, 8'h03, 8'h02, 8'h01};
    localparam logic [NS-1:0]   FIXM  = 6'b001010;

    logic              clk;
    logic              rst;
    logic [NS*32-1:0]  s_rdata;
    logic [NS-1:0]     s_ready;
    logic [NS-1:0]     s_valid;
    logic [31:0]       s_addr;
    logic [31:0]       s_wdata;
    logic [3:0]        s_wstrb;

    int vectors     = 0;
    int miscompares = 0;

    nmi_demux_if bus ();

    nmi_demux #(
        .NUM_SLV     (NS),
        .SLV_BASE    (BASES),
        .FIXLAT_MASK (FIXM),
        .TMO_CYC     (TMO)
    ) dut (
        .clk_i     (clk),
        .rst_i     (rst),
        .m         (bus),
        .s_valid_o (s_valid),
        .s_addr_o  (s_addr),
        .s_wdata_o (s_wdata),
        .s_wstrb_o (s_wstrb),
        .s_rdata_i (s_rdata),
        .s_ready_i (s_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference decode: first slave whose base byte equals addr[31:24], else -1.
    function automatic int ref_decode(input logic [31:0] addr);
        logic [NS*8-1:0] b;
        b = BASES;
        for (int i = 0; i < NS; i++) begin
            if (b[i*8 +: 8] == addr[31:24]) return i;
        end
        return -1;
    endfunction

    function automatic bit ref_fix(input int idx);
        logic [NS-1:0] f;
        f = FIXM;
        return f[idx];
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_txn(input string tag, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [3:0] wstrb, input int d, input logic [31:0] rd);
        int          tgt, vend, total, cap;
        bit          fix, tmo_hit;
        logic        exp_err;
        logic [31:0] exp_rd;
        logic [NS-1:0] oh, exp_sv, noise;
        tgt     = ref_decode(addr);
        fix     = (tgt >= 0) ? ref_fix(tgt) : 1'b0;
        tmo_hit = 1'b0;
`ifdef NMI_DEMUX_TIMEOUT_EN
        if (tgt >= 0 && !fix && d > TMO) tmo_hit = 1'b1;
`endif
        oh = '0;
        if (tgt >= 0) oh[tgt] = 1'b1;
        if (tgt < 0) begin
            vend = 0; total = 2; cap = -1; exp_err = 1'b1; exp_rd = 32'h0;
        end else if (fix) begin
            vend = 1; total = 3; cap = 2; exp_err = 1'b0; exp_rd = rd;
        end else if (tmo_hit) begin
            vend = TMO + 1; total = TMO + 2; cap = -1; exp_err = 1'b1; exp_rd = 32'h0;
        end else begin
            vend = 1 + d; total = 2 + d; cap = 1 + d; exp_err = 1'b0; exp_rd = rd;
        end
        for (int i = 0; i < NS; i++) s_rdata[i*32 +: 32] = $urandom;
        s_ready     = '0;
        bus.m_valid = 1'b1;
        bus.m_addr  = addr;
        bus.m_wdata = wdata;
        bus.m_wstrb = wstrb;
        for (int j = 1; j <= total; j++) begin
            step();
            exp_sv = (j <= vend) ? oh : '0;
            vectors++;
            if (s_valid !== exp_sv) begin
                miscompares++;
                $display("FAIL %s s_valid cyc=%0d got=%b exp=%b", tag, j, s_valid, exp_sv);
            end
            vectors++;
            if (s_wstrb !== ((j <= vend) ? wstrb : 4'h0)) begin
                miscompares++;
                $display("FAIL %s s_wstrb cyc=%0d got=%b exp=%b", tag, j, s_wstrb, (j <= vend) ? wstrb : 4'h0);
            end
            if (j <= vend) begin
                vectors++;
                if (s_addr !== addr || s_wdata !== wdata) begin
                    miscompares++;
                    $display("FAIL %s s_addr/wdata cyc=%0d got=%h/%h exp=%h/%h", tag, j, s_addr, s_wdata, addr, wdata);
                end
            end
            vectors++;
            if (bus.m_ready !== logic'(j == total)) begin
                miscompares++;
                $display("FAIL %s m_ready cyc=%0d got=%b exp=%b", tag, j, bus.m_ready, j == total);
            end
            vectors++;
            if (bus.m_rdata !== ((j == total) ? exp_rd : 32'h0)) begin
                miscompares++;
                $display("FAIL %s m_rdata cyc=%0d got=%h exp=%h", tag, j, bus.m_rdata, (j == total) ? exp_rd : 32'h0);
            end
            vectors++;
            if (bus.m_err !== ((j == total) ? exp_err : 1'b0)) begin
                miscompares++;
                $display("FAIL %s m_err cyc=%0d got=%b exp=%b", tag, j, bus.m_err, (j == total) ? exp_err : 1'b0);
            end
            if (j == total) bus.m_valid = 1'b0;
            // Slave side for the rest of cycle j: noise on other slaves, real ready at T(1+d).
            noise = NS'($urandom);
            if (!fix) noise = noise & ~oh;
            if (tgt >= 0 && !fix && !tmo_hit && j == 1 + d) noise = noise | oh;
            s_ready = noise;
            if (tgt >= 0) s_rdata[tgt*32 +: 32] = (j == cap) ? rd : 32'($urandom);
        end
        step();
        s_ready = '0;
        vectors++;
        if (bus.m_ready !== 1'b0 || s_valid !== '0) begin
            miscompares++;
            $display("FAIL %s idle-after got m_ready=%b s_valid=%b exp 0/0", tag, bus.m_ready, s_valid);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.m_valid = 1'b0; bus.m_addr = 32'h0; bus.m_wdata = 32'h0; bus.m_wstrb = 4'h0;
        s_ready = '0; s_rdata = '0;
        step();
        step();
        vectors++;
        if (s_valid !== '0 || s_wstrb !== 4'h0) begin
            miscompares++; $display("FAIL reset s_valid/wstrb got=%b/%b exp=0/0", s_valid, s_wstrb);
        end
        vectors++;
        if (s_addr !== 32'h0 || s_wdata !== 32'h0) begin
            miscompares++; $display("FAIL reset s_addr/wdata got=%h/%h exp=0/0", s_addr, s_wdata);
        end
        vectors++;
        if (bus.m_ready !== 1'b0 || bus.m_rdata !== 32'h0 || bus.m_err !== 1'b0) begin
            miscompares++; $display("FAIL reset m_* got=%b/%h/%b exp=0/0/0", bus.m_ready, bus.m_rdata, bus.m_err);
        end
        rst = 1'b0;
        step();
    endtask

    task automatic test_handshake_read();
        do_txn("hs_read", 32'h0300_0010, 32'h0, 4'h0, 3, 32'h1234_5678);
        do_txn("hs_min_lat", 32'h0100_0004, 32'h0, 4'h0, 0, 32'hCAFE_0001);
    endtask

    task automatic test_fixlat_write();
        do_txn("fix_write", 32'h0200_0040, 32'hA5A5_0000, 4'b0011, 0, 32'h0BAD_0001);
        do_txn("fix_read", 32'h0400_0008, 32'h0, 4'h0, 0, 32'h7777_1111);
    endtask

    task automatic test_decode_miss();
        do_txn("miss", 32'hFF00_0000, 32'h1, 4'hF, 0, 32'h5555_5555);
    endtask

    task automatic test_priority();
        do_txn("prio", 32'h2000_0100, 32'h0, 4'h0, 1, 32'h2222_4444);
    endtask

    task automatic test_timeout();
`ifdef NMI_DEMUX_TIMEOUT_EN
        do_txn("tmo", 32'h0100_0000, 32'h0, 4'h0, NEVER, 32'h9999_9999);
        do_txn("tmo_edge", 32'h0300_0000, 32'h0, 4'h0, TMO, 32'h1357_9BDF);
`else
        bus.m_valid = 1'b1; bus.m_addr = 32'h0100_0000; bus.m_wdata = 32'h0; bus.m_wstrb = 4'h0;
        s_ready = '0;
        for (int j = 1; j <= 1000; j++) begin
            step();
            vectors++;
            if (bus.m_ready !== 1'b0 || s_valid !== 6'b000001) begin
                miscompares++;
                $display("FAIL stall cyc=%0d got m_ready=%b s_valid=%b exp 0/000001", j, bus.m_ready, s_valid);
            end
            s_ready = NS'($urandom) & 6'b111110;
        end
        rst = 1'b1; bus.m_valid = 1'b0; s_ready = '0;
        step();
        rst = 1'b0;
        vectors++;
        if (s_valid !== '0 || bus.m_ready !== 1'b0) begin
            miscompares++; $display("FAIL stall_reset got s_valid=%b m_ready=%b exp 0/0", s_valid, bus.m_ready);
        end
        step();
`endif
    endtask

    task automatic test_back_to_back();
        do_txn("b2b_a", 32'h0100_0020, 32'h0, 4'h0, 2, 32'hAAAA_0001);
        do_txn("b2b_b", 32'h0300_0030, 32'h0, 4'h0, 1, 32'hBBBB_0002);
        do_txn("b2b_c", 32'h0200_0030, 32'hDEAD_BEEF, 4'b1111, 0, 32'hCCCC_0003);
    endtask

    task automatic test_reset_mid();
        s_ready = '0;
        bus.m_valid = 1'b1; bus.m_addr = 32'h0300_0000; bus.m_wdata = 32'h0; bus.m_wstrb = 4'h0;
        step();
        vectors++;
        if (s_valid !== 6'b000100) begin
            miscompares++; $display("FAIL rstmid access got s_valid=%b exp=000100", s_valid);
        end
        step();
        rst = 1'b1; bus.m_valid = 1'b0;
        step();
        rst = 1'b0;
        vectors++;
        if (s_valid !== '0 || s_wstrb !== 4'h0 || bus.m_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL rstmid after got s_valid=%b s_wstrb=%b m_ready=%b exp 0/0/0", s_valid, s_wstrb, bus.m_ready);
        end
        for (int j = 0; j < 3; j++) begin
            step();
            vectors++;
            if (bus.m_ready !== 1'b0 || s_valid !== '0) begin
                miscompares++; $display("FAIL rstmid quiet got m_ready=%b s_valid=%b exp 0/0", bus.m_ready, s_valid);
            end
        end
        do_txn("rstmid_next", 32'h0300_0044, 32'h0, 4'h0, 2, 32'h0F0F_F0F0);
    endtask

    task automatic test_random();
        logic [NS*8-1:0] b;
        logic [31:0]     addr;
        int              r;
        b = BASES;
        for (int n = 0; n < 40; n++) begin
            r = $urandom_range(0, 5);
            addr = $urandom;
            if (r < 5) addr[31:24] = b[r*8 +: 8];
            else       addr[31:24] = 8'($urandom_range(8'h30, 8'hFF));
            do_txn("rand", addr, $urandom, 4'($urandom), $urandom_range(0, 5), $urandom);
        end
    endtask

    initial begin
        test_reset();
        test_handshake_read();
        test_fixlat_write();
        test_decode_miss();
        test_priority();
        test_timeout();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
